// File: rtl/gates7_checker.sv
// Self-test sequencer for the seven-gate block: steps {a,b} through 00..11,
// samples the six gate outputs after a settle interval and reports the results.
module gates7_checker #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       a,
  output logic       b,
  input  logic       f_and,
  input  logic       f_or,
  input  logic       f_nand,
  input  logic       f_nor,
  input  logic       f_xor,
  input  logic       f_xnor,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] err_mask
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_CHECK  = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  localparam logic [3:0] CNT_RELOAD = 4'(SETTLE_CYCLES - 1);

  function automatic logic [5:0] golden_f(input logic [1:0] v);
    logic ga;
    logic gb;
    ga = v[1];
    gb = v[0];
    return {ga & gb, ga | gb, ~(ga & gb), ~(ga | gb), ga ^ gb, ~(ga ^ gb)};
  endfunction

  state_e     state_q;
  logic [1:0] vec_q;
  logic [3:0] cnt_q;
  logic [2:0] err_count_q;
  logic [2:0] err_count_d;
  logic [3:0] err_mask_q;
  logic       pass_q;
  logic       done_q;
  logic       busy_q;
  logic [5:0] observed_s;
  logic       mismatch_s;

  assign observed_s  = {f_and, f_or, f_nand, f_nor, f_xor, f_xnor};
  // Case inequality: an X or Z on any gate output must count as a failure.
  assign mismatch_s  = (observed_s !== golden_f(vec_q));
  assign err_count_d = err_count_q + {2'b00, mismatch_s};

  // Sequencer state, stimulus vector, settle counter and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      vec_q       <= 2'd0;
      cnt_q       <= 4'd0;
      err_count_q <= 3'd0;
      err_mask_q  <= 4'd0;
      pass_q      <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            vec_q       <= 2'd0;
            cnt_q       <= CNT_RELOAD;
            err_count_q <= 3'd0;
            err_mask_q  <= 4'd0;
            pass_q      <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (cnt_q == 4'd0) begin
            state_q <= S_CHECK;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_CHECK: begin
          if (mismatch_s) begin
            err_mask_q[vec_q] <= 1'b1;
          end
          err_count_q <= err_count_d;
          if (vec_q == 2'd3) begin
            // pass is made visible alongside the done pulse, including this vector
            pass_q  <= (err_count_d == 3'd0);
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            vec_q   <= vec_q + 2'd1;
            cnt_q   <= CNT_RELOAD;
            state_q <= S_SETTLE;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          vec_q   <= 2'd0;
          state_q <= S_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          vec_q   <= 2'd0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign a         = vec_q[1];
  assign b         = vec_q[0];
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_count_q;
  assign err_mask  = err_mask_q;

endmodule

// File: tb/tb_gates7_checker.sv
// Directed bench for gates7_checker: behavioural gate blocks with injectable
// faults, one DUT at SETTLE_CYCLES=1 and one at SETTLE_CYCLES=3.
module tb_gates7_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start1 = 1'b0;
  logic start3 = 1'b0;
  logic stuck_and = 1'b0;
  logic kill_xor = 1'b0;
  logic glitch3 = 1'b0;

  logic a1, b1, busy1, done1, pass1;
  logic [2:0] err_count1;
  logic [3:0] err_mask1;
  logic a3, b3, busy3, done3, pass3;
  logic [2:0] err_count3;
  logic [3:0] err_mask3;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  wire f_and1  = stuck_and ? 1'b1 : (a1 & b1);
  wire f_or1   = a1 | b1;
  wire f_nand1 = ~(a1 & b1);
  wire f_nor1  = ~(a1 | b1);
  wire f_xor1  = kill_xor ? 1'b0 : (a1 ^ b1);
  wire f_xnor1 = ~(a1 ^ b1);

  wire f_or3   = (a3 | b3) ^ glitch3;

  gates7_checker #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
    .f_and(f_and1), .f_or(f_or1), .f_nand(f_nand1), .f_nor(f_nor1),
    .f_xor(f_xor1), .f_xnor(f_xnor1),
    .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err_count1), .err_mask(err_mask1)
  );

  gates7_checker #(.SETTLE_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .a(a3), .b(b3),
    .f_and(a3 & b3), .f_or(f_or3), .f_nand(~(a3 & b3)), .f_nor(~(a3 | b3)),
    .f_xor(a3 ^ b3), .f_xnor(~(a3 ^ b3)),
    .busy(busy3), .done(done3), .pass(pass3),
    .err_count(err_count3), .err_mask(err_mask3)
  );

  // Runs dut1 once; lat = edges after the accepting edge until done is seen,
  // tr = {a,b} in the cycles after edges 0..7 (first sample in the top bits).
  task automatic run1(input bit hold, output int lat, output logic [15:0] tr);
    tr  = 16'h0000;
    lat = 0;
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    if (!hold) start1 = 1'b0;
    while (1) begin
      if (lat < 8) tr = {tr[13:0], a1, b1};
      if (done1 || lat >= 40) break;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({a1, b1, busy1, done1, pass1, err_count1, err_mask1} !== 12'h000) begin
      n_err++;
      $display("FAIL reset_dut1 got %b expected 000000000000",
               {a1, b1, busy1, done1, pass1, err_count1, err_mask1});
    end
    n_vec++;
    if ({a3, b3, busy3, done3, pass3, err_count3, err_mask3} !== 12'h000) begin
      n_err++;
      $display("FAIL reset_dut3 got %b expected 000000000000",
               {a3, b3, busy3, done3, pass3, err_count3, err_mask3});
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({a1, b1, busy1, done1} !== 4'b0000) begin
      n_err++;
      $display("FAIL idle_no_start got %b expected 0000", {a1, b1, busy1, done1});
    end
  endtask

  task automatic test_good_run();
    int lat;
    logic [15:0] tr;
    run1(1'b0, lat, tr);
    n_vec++;
    if (lat !== 8) begin n_err++; $display("FAIL good_latency got %0d expected 8", lat); end
    n_vec++;
    if (tr !== 16'h05AF) begin n_err++; $display("FAIL good_ab_trace got %h expected 05af", tr); end
    n_vec++;
    if ({busy1, pass1, err_count1, err_mask1} !== 9'b1_1_000_0000) begin
      n_err++;
      $display("FAIL good_results got %b expected 110000000", {busy1, pass1, err_count1, err_mask1});
    end
    @(negedge clk);
    n_vec++;
    if ({done1, busy1, a1, b1, pass1} !== 5'b00001) begin
      n_err++;
      $display("FAIL good_after_done got %b expected 00001", {done1, busy1, a1, b1, pass1});
    end
  endtask

  task automatic test_xor_fault();
    int lat;
    logic [15:0] tr;
    kill_xor = 1'b1;
    run1(1'b0, lat, tr);
    kill_xor = 1'b0;
    n_vec++;
    if ({pass1, err_count1, err_mask1} !== 8'b0_010_0110) begin
      n_err++;
      $display("FAIL xor_fault got %b expected 00100110", {pass1, err_count1, err_mask1});
    end
    @(negedge clk);
  endtask

  task automatic test_and_stuck();
    int lat;
    logic [15:0] tr;
    stuck_and = 1'b1;
    run1(1'b0, lat, tr);
    stuck_and = 1'b0;
    n_vec++;
    if ({pass1, err_count1, err_mask1} !== 8'b0_011_0111) begin
      n_err++;
      $display("FAIL and_stuck got %b expected 00110111", {pass1, err_count1, err_mask1});
    end
    @(negedge clk);
    n_vec++;
    if ({pass1, err_count1, err_mask1} !== 8'b0_011_0111) begin
      n_err++;
      $display("FAIL and_stuck_hold got %b expected 00110111", {pass1, err_count1, err_mask1});
    end
    run1(1'b0, lat, tr);
    n_vec++;
    if ({pass1, err_count1, err_mask1} !== 8'b1_000_0000) begin
      n_err++;
      $display("FAIL rerun_clears got %b expected 10000000", {pass1, err_count1, err_mask1});
    end
    @(negedge clk);
  endtask

  task automatic test_start_held();
    int lat;
    int extra_done;
    int extra_busy;
    logic [15:0] tr;
    run1(1'b1, lat, tr);
    n_vec++;
    if (lat !== 8 || tr !== 16'h05AF) begin
      n_err++;
      $display("FAIL held_run got lat=%0d tr=%h expected lat=8 tr=05af", lat, tr);
    end
    // start is still high on the edge that leaves DONE and must be dropped
    @(negedge clk);
    start1 = 1'b0;
    n_vec++;
    if (busy1 !== 1'b0) begin n_err++; $display("FAIL start_in_done got busy=%b expected 0", busy1); end
    extra_done = 0;
    extra_busy = 0;
    repeat (10) begin
      @(negedge clk);
      if (done1) extra_done++;
      if (busy1) extra_busy++;
    end
    n_vec++;
    if (extra_done !== 0 || extra_busy !== 0) begin
      n_err++;
      $display("FAIL held_single_run got done=%0d busy=%0d expected 0 0", extra_done, extra_busy);
    end
  endtask

  task automatic test_midrun_reset();
    int lat;
    int seen_done;
    logic [15:0] tr;
    kill_xor = 1'b1;
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    repeat (4) @(negedge clk);
    n_vec++;
    if ({a1, b1, busy1, err_count1, err_mask1} !== 10'b10_1_001_0010) begin
      n_err++;
      $display("FAIL pre_reset got %b expected 1010010010", {a1, b1, busy1, err_count1, err_mask1});
    end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({a1, b1, busy1, done1, pass1, err_count1, err_mask1} !== 12'h000) begin
      n_err++;
      $display("FAIL async_reset got %b expected 000000000000",
               {a1, b1, busy1, done1, pass1, err_count1, err_mask1});
    end
    kill_xor = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 0;
    repeat (12) begin
      @(negedge clk);
      if (done1 || busy1) seen_done++;
    end
    n_vec++;
    if (seen_done !== 0) begin n_err++; $display("FAIL no_done_after_reset got %0d expected 0", seen_done); end
    run1(1'b0, lat, tr);
    n_vec++;
    if (lat !== 8 || tr !== 16'h05AF || pass1 !== 1'b1) begin
      n_err++;
      $display("FAIL post_reset_run got lat=%0d tr=%h pass=%b expected 8 05af 1", lat, tr, pass1);
    end
    @(negedge clk);
  endtask

  task automatic test_settle3();
    int lat;
    int ab_bad;
    logic [1:0] exp_v;
    ab_bad = 0;
    lat = 0;
    @(negedge clk);
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    while (1) begin
      exp_v = (lat >= 16) ? 2'd3 : 2'(lat / 4);
      if ({a3, b3} !== exp_v) ab_bad++;
      // corrupt f_or everywhere except the CHECK cycles (after edges 3, 7, 11, 15)
      glitch3 = (lat % 4 != 3) && (lat < 16);
      if (done3 || lat >= 60) break;
      @(negedge clk);
      lat++;
    end
    glitch3 = 1'b0;
    n_vec++;
    if (lat !== 16) begin n_err++; $display("FAIL settle3_latency got %0d expected 16", lat); end
    n_vec++;
    if (ab_bad !== 0) begin n_err++; $display("FAIL settle3_ab_hold got %0d bad cycles expected 0", ab_bad); end
    n_vec++;
    if ({busy3, pass3, err_count3, err_mask3} !== 9'b1_1_000_0000) begin
      n_err++;
      $display("FAIL settle3_glitch got %b expected 110000000", {busy3, pass3, err_count3, err_mask3});
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_good_run();
    test_xor_fault();
    test_and_stuck();
    test_start_held();
    test_midrun_reset();
    test_settle3();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
